// File: rtl/freq_sweep_capture.sv
// Frequency-response sweeper: steps the sine_gen period, flushes the filter
// chain at each point and reports the peak-to-peak output per period.
module freq_sweep_capture #(
    parameter int word_width   = 16,
    parameter int period_width = 32,
    parameter int flush_cycles = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [period_width-1:0] start_period,
    input  logic [period_width-1:0] period_step,
    input  logic [period_width-1:0] stop_period,
    input  logic [period_width-1:0] settle_cycles,
    input  logic [period_width-1:0] window_cycles,
    output logic [period_width-1:0] period_out,
    output logic                    gen_rst,
    input  logic [word_width-1:0]   sample_in,
    input  logic                    sample_valid,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [period_width-1:0] result_period,
    output logic [word_width:0]     result_pp,
    output logic                    busy,
    output logic                    done
);

    localparam int PW = period_width;
    localparam int WW = word_width;
    localparam logic [PW-1:0] FLUSH_LAST = PW'(flush_cycles - 1);
    localparam logic signed [WW-1:0] S_MAX = {1'b0, {(WW-1){1'b1}}};
    localparam logic signed [WW-1:0] S_MIN = {1'b1, {(WW-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        SETTLE,
        MEASURE,
        EMIT,
        NEXT
    } state_t;

    state_t state, state_nx;

    logic [PW-1:0]          cnt;
    logic [PW-1:0]          step_q;
    logic [PW-1:0]          stop_q;
    logic [PW-1:0]          settle_q;
    logic [PW-1:0]          window_q;
    logic signed [WW-1:0]   min_q;
    logic signed [WW-1:0]   max_q;
    logic signed [WW-1:0]   smp;
    logic                   seen_q;
    logic [PW:0]            next_sum;
    logic                   sweep_end;
    logic [WW:0]            pp;

    assign smp       = sample_in;
    assign next_sum  = {1'b0, period_out} + {1'b0, step_q};
    assign sweep_end = (step_q == '0) || next_sum[PW]
                       || (next_sum[PW-1:0] > stop_q);
    assign pp        = {max_q[WW-1], max_q} - {min_q[WW-1], min_q};

    assign busy         = (state != IDLE);
    assign result_valid = (state == EMIT);
    assign gen_rst      = (state == SETTLE) || (state == MEASURE)
                          || (state == EMIT) || (state == NEXT);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start && (start_period <= stop_period))
                    state_nx = FLUSH;
            end
            FLUSH: begin
                if (cnt == FLUSH_LAST)
                    state_nx = (settle_q == '0) ? MEASURE : SETTLE;
            end
            SETTLE: begin
                if (cnt == settle_q - PW'(1))
                    state_nx = MEASURE;
            end
            // one extra cycle after the window registers the result
            MEASURE: begin
                if (cnt == window_q)
                    state_nx = EMIT;
            end
            EMIT: begin
                if (result_ready)
                    state_nx = NEXT;
            end
            NEXT: begin
                state_nx = sweep_end ? IDLE : FLUSH;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if ((state_nx != state) || (state == IDLE))
                cnt <= '0;
            else
                cnt <= cnt + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_out    <= '0;
            result_period <= '0;
            result_pp     <= '0;
            done          <= 1'b0;
            step_q        <= '0;
            stop_q        <= '0;
            settle_q      <= '0;
            window_q      <= '0;
            min_q         <= S_MAX;
            max_q         <= S_MIN;
            seen_q        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        step_q   <= period_step;
                        stop_q   <= stop_period;
                        settle_q <= settle_cycles;
                        window_q <= (window_cycles == '0) ? PW'(1)
                                                          : window_cycles;
                        if (start_period > stop_period)
                            done <= 1'b1;
                        else
                            period_out <= start_period;
                    end
                end
                MEASURE: begin
                    if (cnt < window_q) begin
                        if (sample_valid) begin
                            seen_q <= 1'b1;
                            if (smp < min_q) min_q <= smp;
                            if (smp > max_q) max_q <= smp;
                        end
                    end else begin
                        result_pp     <= seen_q ? pp : '0;
                        result_period <= period_out;
                    end
                end
                NEXT: begin
                    if (sweep_end)
                        done <= 1'b1;
                    else
                        period_out <= next_sum[PW-1:0];
                end
                default: ;
            endcase
            if ((state != MEASURE) && (state_nx == MEASURE)) begin
                min_q  <= S_MAX;
                max_q  <= S_MIN;
                seen_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_freq_sweep_capture.sv
// Directed bench for freq_sweep_capture with a result scoreboard.
`timescale 1ns/1ps
module tb_freq_sweep_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_period = '0;
    logic [31:0] period_step = '0;
    logic [31:0] stop_period = '0;
    logic [31:0] settle_cycles = '0;
    logic [31:0] window_cycles = '0;
    logic [31:0] period_out;
    logic        gen_rst;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        result_valid;
    logic        result_ready = 1'b1;
    logic [31:0] result_period;
    logic [16:0] result_pp;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [31:0] per;
        logic [16:0] pp;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   xfers = 0;
    int   lowrun = 0;
    int   smode = 0;

    logic signed [15:0] sine8 [8];

    freq_sweep_capture dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .start_period(start_period),
        .period_step(period_step),
        .stop_period(stop_period),
        .settle_cycles(settle_cycles),
        .window_cycles(window_cycles),
        .period_out(period_out),
        .gen_rst(gen_rst),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_period(result_period),
        .result_pp(result_pp),
        .busy(busy),
        .done(done)
    );

    always #2 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] pp_exp(input int mode);
        case (mode)
            0:       return 17'd65534;
            3:       return 17'd65535;
            default: return 17'd0;
        endcase
    endfunction

    task automatic push_exp(input logic [31:0] sp, input logic [31:0] step,
                            input logic [31:0] stp, input int mode);
        logic [32:0] nxt;
        logic [31:0] p;
        exp_t e;
        p = sp;
        if (sp > stp) return;
        while (1) begin
            e.per = p;
            e.pp  = pp_exp(mode);
            sbq.push_back(e);
            nxt = {1'b0, p} + {1'b0, step};
            if (step == 0 || nxt[32] || nxt[31:0] > stp) break;
            p = nxt[31:0];
        end
    endtask

    task automatic start_sweep(input logic [31:0] sp, input logic [31:0] step,
                               input logic [31:0] stp, input logic [31:0] st,
                               input logic [31:0] win, input int mode);
        push_exp(sp, step, stp, mode);
        @(posedge clk);
        #1;
        smode         = mode;
        start_period  = sp;
        period_step   = step;
        stop_period   = stp;
        settle_cycles = st;
        window_cycles = win;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start         = 1'b0;
        start_period  = $urandom;
        period_step   = $urandom;
        stop_period   = $urandom;
        settle_cycles = $urandom_range(0, 3000);
        window_cycles = $urandom_range(0, 3000);
    endtask

    task automatic wait_done(input int budget, input int exp_x);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        chk("done_seen", 64'(done), 64'(1));
        chk("done_busy", 64'(busy), 64'(0));
        chk("xfer_count", 64'(xfers), 64'(exp_x));
        chk("sb_empty", 64'(sbq.size()), 64'(0));
    endtask

    task automatic chk_reset_vals();
        chk("rst_period_out", 64'(period_out), 64'(0));
        chk("rst_gen_rst", 64'(gen_rst), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_valid", 64'(result_valid), 64'(0));
        chk("rst_res_period", 64'(result_period), 64'(0));
        chk("rst_res_pp", 64'(result_pp), 64'(0));
    endtask

    // sample source: driven a little after each rising edge
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (smode)
                0: begin
                    sample_valid = 1'b1;
                    sample_in    = sine8[ph % 8];
                end
                1: begin
                    sample_valid = 1'b0;
                    sample_in    = 16'sh7FFF;
                end
                2: begin
                    sample_valid = 1'b1;
                    sample_in    = -16'sd5;
                end
                default: begin
                    sample_valid = 1'b1;
                    sample_in    = ph[0] ? 16'sh7FFF : 16'sh8000;
                end
            endcase
            ph++;
        end
    end

    // transfer monitor and flush-length check
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (result_valid && result_ready) begin
                xfers++;
                chk("sb_nonempty", 64'(sbq.size() != 0), 64'(1));
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("res_period", 64'(result_period), 64'(e.per));
                    chk("res_pp", 64'(result_pp), 64'(e.pp));
                end
            end
            if (busy && !gen_rst) begin
                lowrun++;
            end else begin
                if (gen_rst && lowrun != 0)
                    chk("flush_len", 64'(lowrun), 64'(100));
                lowrun = 0;
            end
        end
    end

    initial begin
        int          k;
        logic        stable;
        logic [31:0] p0;
        logic [16:0] pp0;

        sine8[0] = 16'sd0;
        sine8[1] = 16'sd23170;
        sine8[2] = 16'sd32767;
        sine8[3] = 16'sd23170;
        sine8[4] = 16'sd0;
        sine8[5] = -16'sd23170;
        sine8[6] = -16'sd32767;
        sine8[7] = -16'sd23170;

        repeat (3) @(negedge clk);
        chk_reset_vals();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // single point with latency checks
        xfers = 0;
        start_sweep(2, 5, 2, 50, 2048, 0);
        k = 1;
        @(negedge clk);
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_grst", 64'(gen_rst), 64'(0));
        while (!gen_rst && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("grst_rise", 64'(k), 64'(101));
        while (!result_valid && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("valid_latency", 64'(k), 64'(2200));
        wait_done(100, 1);

        // full sweep 2..1000 step 5
        xfers = 0;
        start_sweep(2, 5, 1000, 2, 8, 0);
        wait_done(30000, 200);

        // backpressure
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        xfers = 0;
        start_sweep(40, 1, 40, 0, 16, 3);
        k = 0;
        while (!result_valid && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("bp_valid", 64'(result_valid), 64'(1));
        p0     = result_period;
        pp0    = result_pp;
        stable = 1'b1;
        repeat (500) begin
            @(negedge clk);
            if (!(result_valid && result_period === p0 && result_pp === pp0))
                stable = 1'b0;
        end
        chk("bp_stable", 64'(stable), 64'(1));
        @(posedge clk);
        #1;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_xfer", 64'(xfers), 64'(1));
        chk("bp_clear", 64'(result_valid), 64'(0));
        wait_done(50, 1);

        // reset during MEASURE, then a fresh sweep
        xfers = 0;
        start_sweep(9, 3, 30, 5, 2048, 0);
        k = 0;
        while (!gen_rst && k < 400) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
        chk("pre_rst_period", 64'(period_out), 64'(9));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_reset_vals();
        sbq.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        xfers = 0;
        start_sweep(9, 1, 9, 0, 8, 0);
        wait_done(400, 1);

        // start > stop
        xfers = 0;
        start_sweep(10, 1, 5, 0, 8, 0);
        @(negedge clk);
        chk("rev_done", 64'(done), 64'(1));
        chk("rev_busy", 64'(busy), 64'(0));
        @(negedge clk);
        chk("rev_done_pulse", 64'(done), 64'(0));
        chk("rev_xfers", 64'(xfers), 64'(0));

        // step of zero
        xfers = 0;
        start_sweep(100, 0, 200, 3, 8, 0);
        wait_done(400, 1);

        // carry out ends the sweep
        xfers = 0;
        start_sweep(32'hFFFF_FFFE, 4, 32'hFFFF_FFFF, 0, 8, 3);
        wait_done(400, 1);

        // no valid samples, plus a start while busy
        xfers = 0;
        start_sweep(3, 1, 4, 0, 8, 1);
        repeat (30) @(posedge clk);
        #1;
        start_period = 500;
        stop_period  = 500;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        wait_done(1000, 2);

        // constant input
        xfers = 0;
        start_sweep(7, 2, 11, 1, 0, 2);
        wait_done(1000, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_sweep_capture.md
# freq_sweep_capture

Hardware frequency-response sweeper and capture engine. Steps the `period` input of a `sine_gen` instance through a programmed range and resets the generator and the filter chain it drives at each step. After a settle interval it measures the peak-to-peak amplitude of the filter output and presents one result per period on a valid/ready port for the CPU-side register bank. Sits between the sine generator, a `cascade_low_pass_filter` under test and the readout logic, replacing offline CSV sweeps with on-chip measurement.

## Interface
- `word_width`, 16, sample width (two's complement)
- `period_width`, 32, width of period and all count inputs
- `flush_cycles`, 100, cycles the DUT is held in reset per step
- `clk` in 1, 250 MHz system clock
- `rst` in 1, asynchronous, active-low reset
- `start` in 1, one-cycle request to begin a sweep; ignored while `busy`
- `start_period` in `period_width`, first period value
- `period_step` in `period_width`, increment between points
- `stop_period` in `period_width`, last allowed period (inclusive)
- `settle_cycles` in `period_width`, cycles to wait after DUT reset release
- `window_cycles` in `period_width`, measurement window length in clocks
- `period_out` out `period_width`, drives `sine_gen` period
- `gen_rst` out 1, active-low reset to generator and filter under test
- `sample_in` in `word_width`, filter output
- `sample_valid` in 1, qualifies `sample_in`
- `result_valid` out 1, result available
- `result_ready` in 1, consumer accepts result
- `result_period` out `period_width`, period the result belongs to
- `result_pp` out `word_width`+1, peak-to-peak amplitude (unsigned)
- `busy` out 1, sweep in progress
- `done` out 1, one-cycle pulse at sweep end

## Operation
- States: IDLE, FLUSH, SETTLE, MEASURE, EMIT, NEXT.
- IDLE: `gen_rst`=0, `busy`=0. On `start`, latch all config inputs.
  - If `start_period` > `stop_period`: pulse `done`, stay IDLE, emit no results.
  - Otherwise: `period_out`←`start_period`, go to FLUSH.
- FLUSH: `gen_rst`=0 for exactly `flush_cycles` cycles, then go to SETTLE.
- SETTLE: `gen_rst`=1; count `settle_cycles` cycles, then go to MEASURE. A value of 0 skips directly to MEASURE.
- MEASURE: `gen_rst`=1.
  - On entry: min←most positive value, max←most negative value.
  - Each cycle with `sample_valid`: update min/max (signed compare).
  - Window lasts `window_cycles` clocks; a value of 0 is treated as 1.
  - Then: `result_pp`←max−min, computed in `word_width`+1 bits, unsigned. If no valid sample was seen, `result_pp`=0.
  - `result_period`←`period_out`. Go to EMIT.
- EMIT: `result_valid`=1; data stable until a transfer (`result_valid` & `result_ready` at a rising edge). After the transfer go to NEXT. The generator keeps running during a stall.
- NEXT: form next = `period_out`+`period_step` in `period_width`+1 bits.
  - Sweep ends if `period_step`==0, or carry out, or next > `stop_period`: pulse `done`, go to IDLE.
  - Otherwise `period_out`←next, go to FLUSH.
- `start` while `busy` has no effect. Config input changes mid-sweep are ignored.

## Timing
- Reset values: `period_out`=0, `gen_rst`=0, `busy`=0, `done`=0, `result_valid`=0, `result_period`=0, `result_pp`=0, state IDLE.
- Reset assertion mid-sweep aborts immediately to the reset values. No partial result is emitted.
- `start` sampled at edge N → `busy`=1 and `gen_rst`=0 from N+1. `gen_rst` rises at N+1+`flush_cycles`.
- MEASURE begins `settle_cycles` cycles after `gen_rst` rises. The window covers the next `window_cycles` clocks, and samples valid in the window's last cycle are included.
- `result_valid` rises the cycle after the window ends.
- The transfer cycle clears `result_valid` at the next edge. NEXT takes one cycle. FLUSH restarts the following cycle.
- `done` is high for one cycle, coincident with `busy` falling.
- Per-point latency (ready held high): `flush_cycles` + `settle_cycles` + `window_cycles` + 3 cycles.

## Test plan
- Single point: start=stop=2, step=5, settle=50, window=2048, sine input full scale ±32767 → one result, period 2, pp=65534, then `done`. Exactly 1 transfer.
- Sweep 2..1000 step 5 → 200 results with periods 2,7,…,997. `done` after the 200th transfer. `gen_rst` low exactly 100 cycles per point.
- Backpressure: `result_ready` low for 500 cycles in EMIT → `result_valid`, `result_period` and `result_pp` stable. Transfer occurs on the first ready cycle.
- Boundaries:
  - start=10, stop=5 → `done` the cycle after `start`, no results.
  - step=0 → exactly one result.
  - start=0xFFFF_FFFE, step=4 → one result, carry ends the sweep.
- No valid samples in window (`sample_valid`=0) → pp=0. Constant input −5 → pp=0. Alternating −32768/+32767 → pp=65535.
- Assert `rst` low during MEASURE → all outputs at reset values the same cycle. `start` after release begins a fresh sweep from `start_period`.
